// File: rtl/riscv_fd_ctrl.sv
// riscv_fd_ctrl: front-end sequencing controller for the RV64IMAC F/D pipeline
// register and PC register. It merges I-cache, load-use and mul/div stalls with
// trap, fence.i and branch redirects. Redirects that cannot be issued at once
// are parked in a pending register so that none is ever lost.
// Optional feature macro: RISCV_FDC_STALL_CNT_EN (saturating front-end stall
// cycle counter; when undefined the counter output is tied to zero).
module riscv_fd_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
) (
  input  logic             i_riscv_fdc_clk,
  input  logic             i_riscv_fdc_rst_n,
  input  logic             i_riscv_fdc_icache_stall,
  input  logic             i_riscv_fdc_loaduse,
  input  logic             i_riscv_fdc_muldiv_busy,
  input  logic             i_riscv_fdc_br_redirect,
  input  logic [XLEN-1:0]  i_riscv_fdc_br_target,
  input  logic             i_riscv_fdc_fencei,
  input  logic [XLEN-1:0]  i_riscv_fdc_fencei_target,
  input  logic             i_riscv_fdc_trap_redirect,
  input  logic [XLEN-1:0]  i_riscv_fdc_trap_target,
  input  logic             i_riscv_fdc_inval_done,
  output logic             o_riscv_fdc_pc_stall,
  output logic             o_riscv_fdc_fd_hold,
  output logic             o_riscv_fdc_fd_flush,
  output logic             o_riscv_fdc_de_flush,
  output logic             o_riscv_fdc_redirect_valid,
  output logic [XLEN-1:0]  o_riscv_fdc_redirect_pc,
  output logic             o_riscv_fdc_icache_inval,
  output logic [1:0]       o_riscv_fdc_state,
  output logic [CNT_W-1:0] o_riscv_fdc_stall_cnt
);

  localparam logic [1:0] ST_RUN   = 2'b00;
  localparam logic [1:0] ST_PEND  = 2'b01;
  localparam logic [1:0] ST_FENCE = 2'b10;

  logic [1:0]      state_r;
  logic [1:0]      state_nxt_s;
  logic [XLEN-1:0] pend_r;
  logic [XLEN-1:0] pend_nxt_s;

  logic            pc_stall_s;
  logic            fd_hold_s;
  logic            fd_flush_s;
  logic            de_flush_s;
  logic            rdr_valid_s;
  logic [XLEN-1:0] rdr_pc_s;
  logic            inval_s;
  logic [1:0]      state_dbg_s;
  logic            hz_s;
  logic [XLEN-1:0] run_tgt_s;
  logic [XLEN-1:0] held_tgt_s;

  assign hz_s = i_riscv_fdc_loaduse | i_riscv_fdc_muldiv_busy;

  // Trap outranks branch in RUN; fence.i is handled on its own path.
  assign run_tgt_s = i_riscv_fdc_trap_redirect ? i_riscv_fdc_trap_target
                                               : i_riscv_fdc_br_target;

  // A trap while waiting replaces the parked target, including in the issue cycle.
  assign held_tgt_s = i_riscv_fdc_trap_redirect ? i_riscv_fdc_trap_target : pend_r;

  // Next-state, pending-target and all combinational control outputs.
  always_comb begin
    state_nxt_s = state_r;
    pend_nxt_s  = pend_r;
    pc_stall_s  = 1'b0;
    fd_hold_s   = 1'b0;
    fd_flush_s  = 1'b0;
    de_flush_s  = 1'b0;
    rdr_valid_s = 1'b0;
    rdr_pc_s    = {XLEN{1'b0}};
    inval_s     = 1'b0;
    state_dbg_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (i_riscv_fdc_trap_redirect | (i_riscv_fdc_br_redirect & ~i_riscv_fdc_fencei)) begin
          fd_flush_s = 1'b1;
          de_flush_s = 1'b1;
          if (i_riscv_fdc_icache_stall) begin
            pend_nxt_s  = run_tgt_s;
            state_nxt_s = ST_PEND;
          end else begin
            rdr_valid_s = 1'b1;
            rdr_pc_s    = run_tgt_s;
          end
        end else if (i_riscv_fdc_fencei) begin
          fd_flush_s  = 1'b1;
          de_flush_s  = 1'b1;
          inval_s     = 1'b1;
          pend_nxt_s  = i_riscv_fdc_fencei_target;
          state_nxt_s = ST_FENCE;
        end else begin
          pc_stall_s = hz_s | i_riscv_fdc_icache_stall;
          fd_hold_s  = hz_s;
          fd_flush_s = i_riscv_fdc_icache_stall & ~hz_s;
          de_flush_s = i_riscv_fdc_loaduse & ~i_riscv_fdc_muldiv_busy;
        end
      end
      ST_PEND: begin
        pc_stall_s = 1'b1;
        fd_flush_s = 1'b1;
        de_flush_s = 1'b1;
        pend_nxt_s = held_tgt_s;
        if (!i_riscv_fdc_icache_stall) begin
          rdr_valid_s = 1'b1;
          rdr_pc_s    = held_tgt_s;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      ST_FENCE: begin
        pc_stall_s = 1'b1;
        fd_flush_s = 1'b1;
        de_flush_s = 1'b1;
        pend_nxt_s = held_tgt_s;
        if (i_riscv_fdc_inval_done) begin
          rdr_valid_s = 1'b1;
          rdr_pc_s    = held_tgt_s;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_FENCE;
        end
      end
      default: begin
        // Illegal encoding: quiet outputs and fall back to RUN.
        state_nxt_s = ST_RUN;
        pend_nxt_s  = {XLEN{1'b0}};
        state_dbg_s = ST_RUN;
      end
    endcase
  end

  // State and pending-target registers; reset drops any parked redirect.
  always_ff @(posedge i_riscv_fdc_clk or negedge i_riscv_fdc_rst_n) begin
    if (!i_riscv_fdc_rst_n) begin
      state_r <= ST_RUN;
      pend_r  <= {XLEN{1'b0}};
    end else begin
      state_r <= state_nxt_s;
      pend_r  <= pend_nxt_s;
    end
  end

`ifdef RISCV_FDC_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of cycles in which the PC is held.
  always_ff @(posedge i_riscv_fdc_clk or negedge i_riscv_fdc_rst_n) begin
    if (!i_riscv_fdc_rst_n) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (pc_stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign o_riscv_fdc_stall_cnt = stall_cnt_r;
`else
  assign o_riscv_fdc_stall_cnt = {CNT_W{1'b0}};
`endif

  assign o_riscv_fdc_pc_stall       = pc_stall_s;
  assign o_riscv_fdc_fd_hold        = fd_hold_s;
  assign o_riscv_fdc_fd_flush       = fd_flush_s;
  assign o_riscv_fdc_de_flush       = de_flush_s;
  assign o_riscv_fdc_redirect_valid = rdr_valid_s;
  assign o_riscv_fdc_redirect_pc    = rdr_pc_s;
  assign o_riscv_fdc_icache_inval   = inval_s;
  assign o_riscv_fdc_state          = state_dbg_s;

endmodule

// File: tb/tb_riscv_fd_ctrl.sv
// Self-checking bench for riscv_fd_ctrl: directed vectors, an abstract
// "owed redirect" model compared every cycle, and literal spot checks.
module tb_riscv_fd_ctrl;
  localparam int XLEN    = 64;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ics = 1'b0, lu = 1'b0, md = 1'b0, br = 1'b0, fi = 1'b0, tr = 1'b0, idone = 1'b0;
  logic [XLEN-1:0]  br_t = '0, fi_t = '0, tr_t = '0;
  logic             pcs, hold, fdf, def, rv, inval;
  logic [XLEN-1:0]  rpc;
  logic [1:0]       st;
  logic [CNT_W-1:0] cnt;

  int n_run = 0;
  int n_fail = 0;

  riscv_fd_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .i_riscv_fdc_clk(clk), .i_riscv_fdc_rst_n(rst_n),
    .i_riscv_fdc_icache_stall(ics), .i_riscv_fdc_loaduse(lu), .i_riscv_fdc_muldiv_busy(md),
    .i_riscv_fdc_br_redirect(br), .i_riscv_fdc_br_target(br_t),
    .i_riscv_fdc_fencei(fi), .i_riscv_fdc_fencei_target(fi_t),
    .i_riscv_fdc_trap_redirect(tr), .i_riscv_fdc_trap_target(tr_t),
    .i_riscv_fdc_inval_done(idone),
    .o_riscv_fdc_pc_stall(pcs), .o_riscv_fdc_fd_hold(hold), .o_riscv_fdc_fd_flush(fdf),
    .o_riscv_fdc_de_flush(def), .o_riscv_fdc_redirect_valid(rv), .o_riscv_fdc_redirect_pc(rpc),
    .o_riscv_fdc_icache_inval(inval), .o_riscv_fdc_state(st), .o_riscv_fdc_stall_cnt(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: is a redirect owed, does it wait on invalidation, and to where.
  bit              m_wait = 1'b0, m_fence = 1'b0;
  logic [XLEN-1:0] m_tgt = '0;
  int              m_cnt = 0;
  bit              n_wait, n_fence;
  logic [XLEN-1:0] n_tgt;
  int              n_cnt;

  // Compare process: derive expected outputs from the model and current inputs.
  always @(negedge clk) begin : cmp
    logic e_pcs, e_hold, e_fdf, e_def, e_rv, e_inv, ready;
    logic [XLEN-1:0] e_rpc, t;
    logic [1:0] e_st;
    e_pcs = 0; e_hold = 0; e_fdf = 0; e_def = 0; e_rv = 0; e_inv = 0; e_rpc = '0;
    n_wait = m_wait; n_fence = m_fence; n_tgt = m_tgt;
    e_st = !m_wait ? 2'd0 : (m_fence ? 2'd2 : 2'd1);
    if (!m_wait) begin
      if (tr || br) begin
        e_fdf = 1; e_def = 1;
        t = tr ? tr_t : br_t;
        if (!ics) begin e_rv = 1; e_rpc = t; end
        else begin n_wait = 1; n_fence = 0; n_tgt = t; end
      end else if (fi) begin
        e_fdf = 1; e_def = 1; e_inv = 1;
        n_wait = 1; n_fence = 1; n_tgt = fi_t;
      end else begin
        e_pcs = lu | md | ics;
        e_hold = lu | md;
        e_fdf = ics & !(lu | md);
        e_def = lu & !md;
      end
    end else begin
      e_pcs = 1; e_fdf = 1; e_def = 1;
      t = tr ? tr_t : m_tgt;
      n_tgt = t;
      ready = m_fence ? idone : !ics;
      if (ready) begin e_rv = 1; e_rpc = t; n_wait = 0; end
    end
    n_cnt = (e_pcs && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
    chk("pc_stall", pcs, e_pcs);
    chk("fd_hold", hold, e_hold);
    chk("fd_flush", fdf, e_fdf);
    chk("de_flush", def, e_def);
    chk("redirect_valid", rv, e_rv);
    if (e_rv) chk("redirect_pc", rpc, e_rpc);
    chk("icache_inval", inval, e_inv);
    chk("state", st, e_st);
    chk("hold_flush_excl", hold & fdf, 1'b0);
`ifdef RISCV_FDC_STALL_CNT_EN
    chk("stall_cnt", cnt, m_cnt);
`else
    chk("stall_cnt", cnt, 0);
`endif
  end

  // Advance the model on the clock; async reset clears it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wait <= 0; m_fence <= 0; m_tgt <= '0; m_cnt <= 0;
    end else begin
      m_wait <= n_wait; m_fence <= n_fence; m_tgt <= n_tgt; m_cnt <= n_cnt;
    end
  end

  task automatic idle();
    ics = 0; lu = 0; md = 0; br = 0; fi = 0; tr = 0; idone = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    neg();
    chk("lit_rst_state", st, 2'b00);
    chk("lit_rst_pcs", pcs, 1'b0);
    chk("lit_rst_rv", rv, 1'b0);
    chk("lit_rst_cnt", cnt, 0);
    step(); rst_n = 1;

    lu = 1; neg();
    chk("lit_lu_pcs", pcs, 1'b1); chk("lit_lu_hold", hold, 1'b1);
    chk("lit_lu_def", def, 1'b1); chk("lit_lu_fdf", fdf, 1'b0);
    step(); lu = 1; md = 1; neg();
    chk("lit_lumd_pcs", pcs, 1'b1); chk("lit_lumd_hold", hold, 1'b1); chk("lit_lumd_def", def, 1'b0);
    step(); idle(); ics = 1; neg();
    chk("lit_ics_fdf", fdf, 1'b1); chk("lit_ics_hold", hold, 1'b0);

    step(); idle(); br = 1; br_t = 64'h8000_0100; neg();
    chk("lit_br_rv", rv, 1'b1); chk("lit_br_pc", rpc, 64'h8000_0100);
    chk("lit_br_fdf", fdf, 1'b1); chk("lit_br_def", def, 1'b1);

    step(); br = 1; br_t = 64'h100; ics = 1; neg();
    chk("lit_brst_rv", rv, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(); br = 0; ics = 1; neg();
      chk("lit_pend_state", st, 2'b01); chk("lit_pend_rv", rv, 1'b0);
    end
    step(); ics = 0; neg();
    chk("lit_pend_fire", rv, 1'b1); chk("lit_pend_pc", rpc, 64'h100);
    step(); idle(); neg();
    chk("lit_back_run", st, 2'b00);

    step(); br = 1; br_t = 64'h100; ics = 1;
    step(); br = 0; tr = 1; tr_t = 64'h200; ics = 1;
    step(); tr = 0; ics = 0; neg();
    chk("lit_trap_pend_pc", rpc, 64'h200); chk("lit_trap_pend_rv", rv, 1'b1);

    step(); idle(); fi = 1; fi_t = 64'h404; neg();
    chk("lit_fi_inval", inval, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(); idle(); ics = (i == 1); neg();
      chk("lit_fence_state", st, 2'b10); chk("lit_fence_inval", inval, 1'b0);
    end
    step(); idone = 1; neg();
    chk("lit_fence_rv", rv, 1'b1); chk("lit_fence_pc", rpc, 64'h404);
    step(); idle(); neg();
    chk("lit_fence_run", st, 2'b00);

    step(); fi = 1; fi_t = 64'h500;
    step(); fi = 0; tr = 1; tr_t = 64'h600;
    step(); tr = 0; idone = 1; neg();
    chk("lit_fence_trap_pc", rpc, 64'h600);

    step(); idle(); tr = 1; tr_t = 64'h700; fi = 1; fi_t = 64'h704; ics = 1; neg();
    chk("lit_prio_inval", inval, 1'b0);
    step(); idle(); neg();
    chk("lit_prio_pc", rpc, 64'h700);

    step(); idle(); tr = 1; tr_t = 64'h800; br = 1; br_t = 64'h804; neg();
    chk("lit_prio_trbr", rpc, 64'h800);

    step(); idle();
    for (int i = 0; i < 20; i++) begin
      lu = 1; step();
    end
    lu = 0; neg();
`ifdef RISCV_FDC_STALL_CNT_EN
    chk("lit_cnt_sat", cnt, 4'd15);
`else
    chk("lit_cnt_off", cnt, 4'd0);
`endif

    step(); idle(); br = 1; br_t = 64'h900; ics = 1;
    step(); br = 0; ics = 1; #2;
    rst_n = 0; #1;
    chk("lit_arst_state", st, 2'b00);
    chk("lit_arst_cnt", cnt, 0);
    repeat (2) @(posedge clk);
    #1; rst_n = 1; idle();
    for (int i = 0; i < 3; i++) begin
      neg(); chk("lit_arst_norv", rv, 1'b0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
